// File: rtl/round_timer_ctrl_pkg.sv
// Shared definitions for the game blocks: phase encoding, BCD digit width and
// a helper that splits a 0..99 constant into two BCD digits.
package round_timer_ctrl_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        PHASE_IDLE  = 2'd0,
        PHASE_READY = 2'd1,
        PHASE_PLAY  = 2'd2,
        PHASE_OVER  = 2'd3
    } phase_e;

    // Returns {tens, ones} of a value in 0..99.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 32'd10);
        ones = BCD_W'(value % 32'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/round_timer_ctrl_bcd2_counter.sv
// Two-digit BCD register with load, saturating increment (99) and floored
// decrement (00). Priority: Reset, load, inc, dec.
module bcd2_counter
    import round_timer_ctrl_pkg::*;
#(
    parameter logic [2*BCD_W-1:0] RESET_VALUE = 8'h00
) (
    input  logic               ClockIn,
    input  logic               Reset,
    input  logic               load,
    input  logic [2*BCD_W-1:0] load_value,
    input  logic               inc,
    input  logic               dec,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones,
    output logic               zero
);

    logic at_max_s;

    assign zero     = (tens == BCD_ZERO) && (ones == BCD_ZERO);
    assign at_max_s = (tens == BCD_NINE) && (ones == BCD_NINE);

    // Digit registers with load / inc / dec.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            tens <= RESET_VALUE[2*BCD_W-1:BCD_W];
            ones <= RESET_VALUE[BCD_W-1:0];
        end else if (load) begin
            tens <= load_value[2*BCD_W-1:BCD_W];
            ones <= load_value[BCD_W-1:0];
        end else if (inc) begin
            if (at_max_s) begin
                tens <= tens;
                ones <= ones;
            end else if (ones == BCD_NINE) begin
                tens <= tens + 4'd1;
                ones <= BCD_ZERO;
            end else begin
                ones <= ones + 4'd1;
            end
        end else if (dec) begin
            if (zero) begin
                tens <= tens;
                ones <= ones;
            end else if (ones == BCD_ZERO) begin
                tens <= tens - 4'd1;
                ones <= BCD_NINE;
            end else begin
                ones <= ones - 4'd1;
            end
        end else begin
            tens <= tens;
            ones <= ones;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round controller: IDLE -> READY countdown -> PLAY -> OVER, with a BCD
// time-left counter and a saturating BCD hit score.
module round_timer_ctrl
    import round_timer_ctrl_pkg::*;
#(
    parameter int ROUND_SECONDS    = 60,
    parameter int PRESTART_SECONDS = 3
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic             SecTick,
    input  logic             Start,
    input  logic             HitIn,
    output logic [1:0]       Phase,
    output logic [BCD_W-1:0] TimeOnes,
    output logic [BCD_W-1:0] TimeTens,
    output logic [BCD_W-1:0] ScoreOnes,
    output logic [BCD_W-1:0] ScoreTens,
    output logic [3:0]       ReadyLeft,
    output logic             GameActive,
    output logic             GameOver
);

    localparam logic [2*BCD_W-1:0] ROUND_BCD     = to_bcd2(ROUND_SECONDS);
    localparam logic [3:0]         PRESTART_LOAD = 4'(PRESTART_SECONDS);

    phase_e phase_r;
    logic   start_prev_r;
    logic   hit_prev_r;

    logic start_rise_s;
    logic hit_rise_s;
    logic round_load_s;
    logic time_dec_s;
    logic score_inc_s;
    logic time_zero_s;
    logic time_last_s;
    logic score_zero_unused_s;

    assign start_rise_s = Start & ~start_prev_r;
    assign hit_rise_s   = HitIn & ~hit_prev_r;
    assign Phase        = phase_r;

    // A zero time in PLAY cannot occur, but it is treated as the final tick too.
    assign time_last_s = time_zero_s ||
                         ((TimeTens == BCD_ZERO) && (TimeOnes == 4'd1));

    // Counter controls derived from the current phase and detected edges.
    always_comb begin
        round_load_s = 1'b0;
        time_dec_s   = 1'b0;
        score_inc_s  = 1'b0;
        case (phase_r)
            PHASE_PLAY: begin
                time_dec_s  = SecTick;
                score_inc_s = hit_rise_s;
            end
            PHASE_READY: begin
                round_load_s = 1'b0;
            end
            PHASE_OVER: begin
                round_load_s = start_rise_s;
            end
            default: begin
                round_load_s = start_rise_s;
            end
        endcase
    end

    // Phase sequencing, READY countdown, status flags and edge history.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            phase_r      <= PHASE_IDLE;
            ReadyLeft    <= 4'd0;
            GameActive   <= 1'b0;
            GameOver     <= 1'b0;
            start_prev_r <= 1'b1;
            hit_prev_r   <= 1'b1;
        end else begin
            start_prev_r <= Start;
            hit_prev_r   <= HitIn;
            case (phase_r)
                PHASE_READY: begin
                    if (SecTick) begin
                        if (ReadyLeft <= 4'd1) begin
                            phase_r    <= PHASE_PLAY;
                            ReadyLeft  <= 4'd0;
                            GameActive <= 1'b1;
                        end else begin
                            ReadyLeft <= ReadyLeft - 4'd1;
                        end
                    end else begin
                        ReadyLeft <= ReadyLeft;
                    end
                end
                PHASE_PLAY: begin
                    if (SecTick && time_last_s) begin
                        phase_r    <= PHASE_OVER;
                        GameActive <= 1'b0;
                        GameOver   <= 1'b1;
                    end else begin
                        phase_r <= PHASE_PLAY;
                    end
                end
                default: begin
                    // IDLE and OVER both restart the round on a Start rise.
                    if (start_rise_s) begin
                        phase_r    <= PHASE_READY;
                        ReadyLeft  <= PRESTART_LOAD;
                        GameActive <= 1'b0;
                        GameOver   <= 1'b0;
                    end else begin
                        phase_r <= phase_r;
                    end
                end
            endcase
        end
    end

    bcd2_counter #(
        .RESET_VALUE(ROUND_BCD)
    ) u_time (
        .ClockIn   (ClockIn),
        .Reset     (Reset),
        .load      (round_load_s),
        .load_value(ROUND_BCD),
        .inc       (1'b0),
        .dec       (time_dec_s),
        .tens      (TimeTens),
        .ones      (TimeOnes),
        .zero      (time_zero_s)
    );

    bcd2_counter #(
        .RESET_VALUE(8'h00)
    ) u_score (
        .ClockIn   (ClockIn),
        .Reset     (Reset),
        .load      (round_load_s),
        .load_value(8'h00),
        .inc       (score_inc_s),
        .dec       (1'b0),
        .tens      (ScoreTens),
        .ones      (ScoreOnes),
        .zero      (score_zero_unused_s)
    );

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with hand-derived expectations.
module tb_round_timer_ctrl;

    logic       ClockIn;
    logic       Reset;
    logic       SecTick;
    logic       Start;
    logic       HitIn;
    logic [1:0] Phase;
    logic [3:0] TimeOnes;
    logic [3:0] TimeTens;
    logic [3:0] ScoreOnes;
    logic [3:0] ScoreTens;
    logic [3:0] ReadyLeft;
    logic       GameActive;
    logic       GameOver;

    int n_checks = 0;
    int n_fail   = 0;

    round_timer_ctrl #(
        .ROUND_SECONDS   (60),
        .PRESTART_SECONDS(3)
    ) dut (
        .ClockIn   (ClockIn),
        .Reset     (Reset),
        .SecTick   (SecTick),
        .Start     (Start),
        .HitIn     (HitIn),
        .Phase     (Phase),
        .TimeOnes  (TimeOnes),
        .TimeTens  (TimeTens),
        .ScoreOnes (ScoreOnes),
        .ScoreTens (ScoreTens),
        .ReadyLeft (ReadyLeft),
        .GameActive(GameActive),
        .GameOver  (GameOver)
    );

    initial ClockIn = 1'b0;
    always #10 ClockIn = ~ClockIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic step();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic tick();
        SecTick = 1'b1;
        step();
        SecTick = 1'b0;
    endtask

    task automatic hit();
        HitIn = 1'b1;
        step();
        HitIn = 1'b0;
        step();
    endtask

    task automatic press_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_phase"}, 32'(Phase), 32'd0);
        check({tag, "_time"}, 32'({TimeTens, TimeOnes}), 32'h60);
        check({tag, "_score"}, 32'({ScoreTens, ScoreOnes}), 32'h00);
        check({tag, "_ready"}, 32'(ReadyLeft), 32'd0);
        check({tag, "_flags"}, 32'({GameActive, GameOver}), 32'd0);
    endtask

    initial begin
        Reset   = 1'b1;
        SecTick = 1'b0;
        Start   = 1'b0;
        HitIn   = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();

        // 1: reset state, start, READY countdown
        check_idle_reset("rst");
        Start = 1'b1;
        step();
        check("start_phase", 32'(Phase), 32'd1);
        check("start_ready", 32'(ReadyLeft), 32'd3);
        Start = 1'b0;
        step();
        tick();
        check("ready_2", 32'(ReadyLeft), 32'd2);
        step();
        tick();
        check("ready_1", 32'(ReadyLeft), 32'd1);
        tick();
        check("play_phase", 32'(Phase), 32'd2);
        check("play_ready", 32'(ReadyLeft), 32'd0);
        check("play_time", 32'({TimeTens, TimeOnes}), 32'h60);
        check("play_active", 32'({GameActive, GameOver}), 32'b10);

        // 2: 60 seconds of countdown with BCD borrows
        for (int i = 1; i <= 60; i++) begin
            tick();
            check("countdown", 32'({TimeTens, TimeOnes}), bcd(60 - i));
            if (i < 60) begin
                check("countdown_phase", 32'(Phase), 32'd2);
            end
            step();
        end
        check("over_phase", 32'(Phase), 32'd3);
        check("over_flags", 32'({GameActive, GameOver}), 32'b01);
        tick();
        check("over_floor", 32'({TimeTens, TimeOnes}), 32'h00);

        // 3: score saturation and held hit level
        press_start();
        for (int i = 0; i < 3; i++) tick();
        check("r2_phase", 32'(Phase), 32'd2);
        HitIn = 1'b1;
        for (int i = 0; i < 20; i++) step();
        HitIn = 1'b0;
        step();
        check("held_hit", 32'({ScoreTens, ScoreOnes}), 32'h01);
        for (int i = 2; i <= 105; i++) begin
            hit();
            if (i == 9 || i == 10 || i == 99 || i == 105) begin
                check("score", 32'({ScoreTens, ScoreOnes}), bcd(i > 99 ? 99 : i));
            end
        end
        for (int i = 0; i < 60; i++) tick();
        check("r2_over", 32'(Phase), 32'd3);
        check("r2_score_hold", 32'({ScoreTens, ScoreOnes}), 32'h99);

        // 5 (part): restart from OVER clears score and reloads time
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("restart_phase", 32'(Phase), 32'd1);
        check("restart_score", 32'({ScoreTens, ScoreOnes}), 32'h00);
        check("restart_time", 32'({TimeTens, TimeOnes}), 32'h60);
        step();
        hit();
        check("ready_hit_ignored", 32'({ScoreTens, ScoreOnes}), 32'h00);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 59; i++) tick();
        check("r3_time_01", 32'({TimeTens, TimeOnes}), 32'h01);
        press_start();
        check("play_start_ignored", 32'(Phase), 32'd2);

        // 4: hit rise on the final tick counts, the next one does not
        SecTick = 1'b1;
        HitIn   = 1'b1;
        step();
        SecTick = 1'b0;
        HitIn   = 1'b0;
        check("final_hit_score", 32'({ScoreTens, ScoreOnes}), 32'h01);
        check("final_hit_time", 32'({TimeTens, TimeOnes}), 32'h00);
        check("final_hit_phase", 32'(Phase), 32'd3);
        HitIn = 1'b1;
        step();
        HitIn = 1'b0;
        step();
        check("late_hit", 32'({ScoreTens, ScoreOnes}), 32'h01);

        // 5: Start held through reset release does not fire
        Reset = 1'b1;
        Start = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        step();
        step();
        check("held_start_phase", 32'(Phase), 32'd0);
        Start = 1'b0;
        step();
        Start = 1'b1;
        step();
        check("repress_phase", 32'(Phase), 32'd1);
        Start = 1'b0;
        step();

        // 6: reset mid-PLAY at time 37, score 12
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 23; i++) tick();
        for (int i = 0; i < 12; i++) hit();
        check("pre_rst_time", 32'({TimeTens, TimeOnes}), 32'h37);
        check("pre_rst_score", 32'({ScoreTens, ScoreOnes}), 32'h12);
        Reset   = 1'b1;
        SecTick = 1'b1;
        step();
        Reset   = 1'b0;
        SecTick = 1'b0;
        check_idle_reset("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
